fifo_fanout: RTL and testbench
==============================

FIFO_FANOUT -- requirements
Module: fifo_fanout

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample width in bits.
REQ-002 Parameter NUM_CH, default 2, number of output FIFO channels; legal range 2..8.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 mode  input  1  0 = broadcast (every sample to all channels); 1 = round-robin (each sample to one channel).
REQ-006 in_dout  input  DATA_WIDTH  head word of the show-ahead input FIFO, valid while in_empty=0.
REQ-007 in_empty  input  1  input FIFO empty flag.
REQ-008 in_rd_en  output  1  input FIFO pop strobe.
REQ-009 out_din  output  NUM_CH*DATA_WIDTH  per-channel write data; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 out_full  input  NUM_CH  per-channel output FIFO full flags.
REQ-011 out_wr_en  output  NUM_CH  per-channel output FIFO write strobes.
REQ-012 busy  output  1  high while a held sample has undelivered channels.

Function
REQ-013 The block SHALL use two states, IDLE and DIST, plus a DATA_WIDTH hold register, an NUM_CH pending mask and a rr_ptr of clog2(NUM_CH) bits.
REQ-014 IDLE: if in_empty=0, the block SHALL assert in_rd_en for exactly one cycle, capture in_dout into hold, sample mode, load pending, and go to DIST.
REQ-015 Pending load SHALL be all ones when the sampled mode=0, and the one-hot bit of rr_ptr when mode=1.
REQ-016 mode SHALL be sampled only at load; changes while in DIST SHALL NOT affect the held sample.
REQ-017 DIST: for each channel k with pending[k]=1 and out_full[k]=0, the block SHALL assert out_wr_en[k], drive hold on lane k, and clear pending[k] at the next edge.
REQ-018 Channels SHALL be serviced independently; a full channel SHALL NOT block writes to non-full pending channels.
REQ-019 out_wr_en[k] SHALL never assert when out_full[k]=1 or pending[k]=0; each held sample SHALL be written at most once per channel.
REQ-020 Lanes not write-enabled in a cycle SHALL drive 0.
REQ-021 When every remaining pending channel is written this cycle: if in_empty=0, the block SHALL pop and load the next sample in the same cycle and stay in DIST; otherwise it SHALL return to IDLE.
REQ-022 Sustained throughput SHALL be one sample per cycle when no output channel is full.
REQ-023 In round-robin mode rr_ptr SHALL advance by one on completion of each sample, wrapping NUM_CH-1 -> 0; in broadcast mode rr_ptr SHALL hold its value.
REQ-024 Latency SHALL be one cycle: a sample popped at edge N is written to an output no earlier than the cycle following edge N.
REQ-025 busy SHALL equal (state==DIST).
REQ-026 An unreachable state encoding SHALL recover to IDLE on the next edge.

Reset
REQ-027 When reset is asserted, the block SHALL immediately enter IDLE with hold=0, pending=0 and rr_ptr=0; in_rd_en, out_wr_en, out_din and busy SHALL be 0.
REQ-028 Reset asserted mid-DIST SHALL discard the held sample without writing the undelivered channels.

Verification
REQ-029 NUM_CH=2, mode=0, input 0x11,0x22,0x33, no full -> both channels receive 0x11,0x22,0x33 on consecutive cycles; in_rd_en high for 3 consecutive cycles.
REQ-030 NUM_CH=4, mode=0, out_full[2]=1 for 5 cycles -> channels 0,1,3 write 0xAA immediately; ch2 writes 0xAA 1 cycle after full drops; no further pop until then.
REQ-031 NUM_CH=3, mode=1, input 1..7 -> ch0 gets 1,4,7; ch1 gets 2,5; ch2 gets 3,6; rr_ptr ends at 1.
REQ-032 mode toggled 0->1 while sample 0x55 is held in DIST -> 0x55 still delivered to all channels; the next sample goes only to channel rr_ptr.
REQ-033 Reset pulsed while ch1 full with 0xBEEF pending -> 0xBEEF never written to ch1; after reset all outputs 0, busy=0, next sample goes to ch0 in mode=1.
REQ-034 Random full/empty stress, 10k samples -> per-channel scoreboards match, no write while full, no duplicate writes.

Source files
------------

// File: rtl/fifo_fanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_fanout: distributes samples from one show-ahead FIFO to NUM_CH FIFOs   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module fifo_fanout #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         mode,
  input  logic [DATA_WIDTH-1:0]        in_dout,
  input  logic                         in_empty,
  output logic                         in_rd_en,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_din,
  input  logic [NUM_CH-1:0]            out_full,
  output logic [NUM_CH-1:0]            out_wr_en,
  output logic                         busy
);

  localparam int c_PTR_W = $clog2(NUM_CH);
  localparam logic [c_PTR_W-1:0] c_PTR_MAX = c_PTR_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0]  c_ONE     = {{(NUM_CH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIST = 2'b01
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_hold;
  logic                  r_mode;
  logic [NUM_CH-1:0]     r_pending;
  logic [NUM_CH-1:0]     w_pending_nxt;
  logic [NUM_CH-1:0]     w_wr;
  logic [c_PTR_W-1:0]    r_rr_ptr;
  logic [c_PTR_W-1:0]    w_rr_ptr_nxt;
  logic [c_PTR_W-1:0]    w_rr_ptr_inc;
  logic                  w_load;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = IDLE;
    w_wr          = '0;
    w_load        = 1'b0;
    w_pending_nxt = r_pending;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_rr_ptr_inc  = (r_rr_ptr == c_PTR_MAX) ? '0 : r_rr_ptr + 1'b1;
    case (r_state)
      IDLE: begin
        w_load      = ~in_empty;
        w_state_nxt = w_load ? DIST : IDLE;
      end
      DIST: begin
        w_wr          = r_pending & ~out_full;
        w_pending_nxt = r_pending & ~w_wr;
        w_state_nxt   = DIST;
        if (w_pending_nxt == '0) begin
          // Completion: advance the pointer first so a back-to-back load uses it
          if (r_mode) w_rr_ptr_nxt = w_rr_ptr_inc;
          w_load      = ~in_empty;
          w_state_nxt = w_load ? DIST : IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_load) begin
      w_pending_nxt = mode ? (c_ONE << w_rr_ptr_nxt) : '1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold    <= '0;
      r_mode    <= 1'b0;
      r_pending <= '0;
      r_rr_ptr  <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      if (w_load) begin
        r_hold <= in_dout;
        r_mode <= mode;
      end
    end
  end

  // Reset gates the pop strobe since IDLE would otherwise pop during reset
  assign in_rd_en  = w_load & ~reset;
  assign out_wr_en = w_wr;
  assign busy      = (r_state == DIST);

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      assign out_din[k*DATA_WIDTH +: DATA_WIDTH] = w_wr[k] ? r_hold : '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_fanout.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_fanout: directed and randomized checks against a queue model        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_fifo_fanout;

  localparam int DW  = 16;
  localparam int NCH = 4;

  logic                clock = 1'b0;
  logic                reset;
  logic                mode;
  logic [DW-1:0]       in_dout;
  logic                in_empty;
  logic                in_rd_en;
  logic [NCH*DW-1:0]   out_din;
  logic [NCH-1:0]      out_full;
  logic [NCH-1:0]      out_wr_en;
  logic                busy;

  always #5 clock = ~clock;

  fifo_fanout #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .in_dout(in_dout), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en), .busy(busy)
  );

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] in_q[$];
  logic [DW-1:0] exp_q[NCH][$];
  int            rr_cnt;
  bit            pop_pend;
  logic          obs_rd;
  logic [NCH-1:0] obs_wr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic apply_in();
    in_empty = (in_q.size() == 0);
    in_dout  = in_empty ? '0 : in_q[0];
  endtask

  task automatic clear_model();
    for (int k = 0; k < NCH; k++) exp_q[k].delete();
    rr_cnt   = 0;
    pop_pend = 0;
  endtask

  // Sampled at the falling edge; inputs stay stable until the next rising edge
  task automatic monitor();
    logic any;
    logic [DW-1:0] lane;
    obs_rd = in_rd_en;
    obs_wr = out_wr_en;
    any = 1'b0;
    for (int k = 0; k < NCH; k++) any |= (exp_q[k].size() != 0);
    check("busy", busy, any);
    check("wr_while_full", out_wr_en & out_full, 0);
    for (int k = 0; k < NCH; k++) begin
      lane = out_din[k*DW +: DW];
      if (out_wr_en[k]) begin
        check($sformatf("ch%0d_expected", k), exp_q[k].size() != 0, 1);
        if (exp_q[k].size() != 0) check($sformatf("ch%0d_data", k), lane, exp_q[k].pop_front());
      end else begin
        check($sformatf("ch%0d_idle_zero", k), lane, 0);
      end
    end
    if (in_rd_en) begin
      check("pop_when_empty", in_empty, 0);
      if (!in_empty) begin
        if (mode == 1'b0) begin
          for (int k = 0; k < NCH; k++) exp_q[k].push_back(in_q[0]);
        end else begin
          exp_q[rr_cnt % NCH].push_back(in_q[0]);
          rr_cnt++;
        end
        pop_pend = 1;
      end
    end
  endtask

  task automatic step();
    @(negedge clock);
    monitor();
    @(posedge clock);
    #1;
    if (pop_pend) begin
      void'(in_q.pop_front());
      pop_pend = 0;
    end
    apply_in();
  endtask

  task automatic expect_cycle(input string tag, input logic erd, input logic [NCH-1:0] ewr);
    step();
    check({tag, "_rd"}, obs_rd, erd);
    check({tag, "_wr"}, obs_wr, ewr);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    #1;
    check("rst_busy", busy, 0);
    check("rst_rd", in_rd_en, 0);
    check("rst_wr", out_wr_en, 0);
    check("rst_din", out_din, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int pushed;
    int cyc;
    reset = 1'b1; mode = 1'b0; out_full = '0;
    apply_in();
    clear_model();
    @(posedge clock); #1;
    do_reset();

    // Broadcast stream: one pop per cycle, both outputs back-to-back
    in_q.push_back(16'h11); in_q.push_back(16'h22); in_q.push_back(16'h33); apply_in();
    expect_cycle("t1c1", 1, 4'b0000);
    expect_cycle("t1c2", 1, 4'b1111);
    expect_cycle("t1c3", 1, 4'b1111);
    expect_cycle("t1c4", 0, 4'b1111);
    expect_cycle("t1c5", 0, 4'b0000);

    // One full channel stalls only itself and blocks the next pop
    out_full = 4'b0100;
    in_q.push_back(16'hAA); in_q.push_back(16'hBB); apply_in();
    expect_cycle("t2c1", 1, 4'b0000);
    expect_cycle("t2c2", 0, 4'b1011);
    for (int i = 0; i < 4; i++) expect_cycle("t2stall", 0, 4'b0000);
    out_full = 4'b0000;
    expect_cycle("t2c7", 1, 4'b0100);
    expect_cycle("t2c8", 0, 4'b1111);
    expect_cycle("t2c9", 0, 4'b0000);

    // Round-robin over 7 samples, then the 8th lands on channel 7 mod 4
    do_reset();
    mode = 1'b1;
    for (int i = 1; i <= 7; i++) in_q.push_back(DW'(i));
    apply_in();
    for (int i = 0; i < 9; i++) step();
    in_q.push_back(16'h0008); apply_in();
    expect_cycle("t3pop", 1, 4'b0000);
    expect_cycle("t3ch3", 0, 4'b1000);

    // Mode change while held does not retarget the held sample
    do_reset();
    mode = 1'b0; out_full = 4'b0001;
    in_q.push_back(16'h55); in_q.push_back(16'h66); apply_in();
    expect_cycle("t4c1", 1, 4'b0000);
    mode = 1'b1;
    expect_cycle("t4c2", 0, 4'b1110);
    out_full = 4'b0000;
    expect_cycle("t4c3", 1, 4'b0001);
    expect_cycle("t4c4", 0, 4'b0001);
    expect_cycle("t4c5", 0, 4'b0000);

    // Asynchronous reset drops a sample pending on a full channel
    do_reset();
    mode = 1'b1; out_full = 4'b0010;
    in_q.push_back(16'h1111); in_q.push_back(16'hBEEF); apply_in();
    expect_cycle("t5c1", 1, 4'b0000);
    expect_cycle("t5c2", 1, 4'b0001);
    expect_cycle("t5c3", 0, 4'b0000);
    in_q.push_back(16'h7777); apply_in();
    do_reset();
    out_full = 4'b0000;
    expect_cycle("t5pop", 1, 4'b0000);
    expect_cycle("t5ch0", 0, 4'b0001);

    // Random stress
    pushed = 0;
    cyc = 0;
    mode = 1'b0;
    while (cyc < 60000 && pushed < 10000) begin
      if (in_q.size() < 8 && $urandom_range(0, 9) < 7) begin
        in_q.push_back(DW'($urandom));
        pushed++;
      end
      for (int k = 0; k < NCH; k++) out_full[k] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 31) == 0) mode = ~mode;
      apply_in();
      step();
      cyc++;
    end
    check("stress_all_pushed", pushed, 10000);
    out_full = '0;
    cyc = 0;
    while (cyc < 200 && (in_q.size() != 0 || busy)) begin
      step();
      cyc++;
    end
    check("drain_in_empty", in_q.size(), 0);
    for (int k = 0; k < NCH; k++) check($sformatf("drain_ch%0d", k), exp_q[k].size(), 0);
    check("drain_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
